// File: rtl/pul_period_prefetch_if.sv
// DDR burst read port of the pulse-period prefetcher: request channel plus data return.
// Latency: none, wires only.
// Backpressure: rd_req_ready stalls the request; the data channel cannot be stalled.
interface pul_period_prefetch_if;
  logic        rd_req_valid;
  logic        rd_req_ready;
  logic [31:0] rd_req_addr;
  logic [7:0]  rd_req_len;
  logic        rd_data_valid;
  logic [31:0] rd_data;

  // Prefetcher side issues requests and sinks data.
  modport master (
    output rd_req_valid, rd_req_addr, rd_req_len,
    input  rd_req_ready, rd_data_valid, rd_data
  );

  // DDR reader side accepts requests and returns data.
  modport slave (
    input  rd_req_valid, rd_req_addr, rd_req_len,
    output rd_req_ready, rd_data_valid, rd_data
  );
endinterface

// File: rtl/pul_period_prefetch.sv
// Prefetches pulse-period words from DDR in bursts into a FWFT FIFO feeding the pulse controller.
// Latency: start->rd_req_valid 2 cycles; beat->pul_value 1 cycle; read pops on the same edge.
// Backpressure: a burst is requested only once the FIFO has room for all of it; data beats are never stalled.
// Optional feature: define PREFETCH_LAST_HOLD_EN to hold the last popped word on pul_value while empty.
module pul_period_prefetch #(
  parameter int DEPTH = 16,
  parameter int BURST = 8
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        start,
  input  logic                        abort,
  input  logic [31:0]                 base_addr,
  input  logic [31:0]                 total_words,
  pul_period_prefetch_if.master       rd,
  input  logic                        read,
  output logic [31:0]                 pul_value,
  output logic                        empty,
  output logic                        busy,
  output logic                        done,
  output logic                        underrun
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [31:0] DEPTH_W = DEPTH;
  localparam logic [31:0] BURST_W = BURST;

  typedef enum logic [2:0] {IDLE, CHECK, REQ, DATA, DRAIN} state_t;

  state_t        state;
  logic [31:0]   addr;
  logic [31:0]   remaining;
  logic [7:0]    beat_cnt;

  logic [31:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;

  logic [7:0]    burst_len;
  logic [31:0]   free_slots;
  logic          room;
  logic          last_beat;
  logic          push;
  logic          pop;

  assign burst_len  = (remaining < BURST_W) ? remaining[7:0] : BURST_W[7:0];
  assign free_slots = DEPTH_W - 32'(count);
  assign room       = free_slots >= {24'd0, burst_len};
  assign last_beat  = rd.rd_data_valid && (beat_cnt == 8'd1);
  // Beats that arrive during an abort belong to a cancelled burst and are dropped.
  assign push       = (state == DATA) && rd.rd_data_valid && !abort;
  assign pop        = read && !empty && !abort;
  assign empty      = (count == '0);
  assign busy       = (state != IDLE);

  // Fetch sequencer: one outstanding burst, sized only when the FIFO can absorb it whole.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= IDLE;
      addr            <= '0;
      remaining       <= '0;
      beat_cnt        <= '0;
      rd.rd_req_valid <= 1'b0;
      rd.rd_req_addr  <= '0;
      rd.rd_req_len   <= '0;
      done            <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start && !abort) begin
            addr      <= base_addr;
            remaining <= total_words;
            if (total_words == '0) done  <= 1'b1;
            else                   state <= CHECK;
          end
        end
        CHECK: begin
          if (abort) begin
            state <= IDLE;
          end else if (room) begin
            rd.rd_req_valid <= 1'b1;
            rd.rd_req_addr  <= addr;
            rd.rd_req_len   <= burst_len;
            state           <= REQ;
          end
        end
        REQ: begin
          if (abort) begin
            rd.rd_req_valid <= 1'b0;
            state           <= IDLE;
          end else if (rd.rd_req_ready) begin
            rd.rd_req_valid <= 1'b0;
            beat_cnt        <= rd.rd_req_len;
            state           <= DATA;
          end
        end
        DATA: begin
          if (rd.rd_data_valid) beat_cnt <= beat_cnt - 8'd1;
          if (abort) begin
            // If the abort lands on the final beat there is nothing left to swallow.
            state <= last_beat ? IDLE : DRAIN;
          end else if (last_beat) begin
            addr      <= addr + {22'd0, rd.rd_req_len, 2'b00};
            remaining <= remaining - {24'd0, rd.rd_req_len};
            if (remaining == {24'd0, rd.rd_req_len}) begin
              done  <= 1'b1;
              state <= IDLE;
            end else begin
              state <= CHECK;
            end
          end
        end
        DRAIN: begin
          if (rd.rd_data_valid) begin
            beat_cnt <= beat_cnt - 8'd1;
            if (beat_cnt == 8'd1) state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Sticky underrun: a pop on an empty FIFO; cleared when a new job is accepted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                      underrun <= 1'b0;
    else if (read && empty)                          underrun <= 1'b1;
    else if ((state == IDLE) && start && !abort)     underrun <= 1'b0;
  end

  // FIFO pointers and occupancy; abort flushes everything in one cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (abort) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // FIFO storage write; contents need no reset since occupancy gates every read.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= rd.rd_data;
  end

`ifdef PREFETCH_LAST_HOLD_EN
  logic [31:0] last_word;

  // Remember the most recently consumed word so the controller sees it while starved.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     last_word <= '0;
    else if (abort) last_word <= '0;
    else if (pop)   last_word <= mem[rd_ptr];
  end

  assign pul_value = empty ? last_word : mem[rd_ptr];
`else
  assign pul_value = empty ? 32'd0 : mem[rd_ptr];
`endif

endmodule

// File: tb/tb_pul_period_prefetch.sv
// Self-checking bench for pul_period_prefetch: behavioural queue model plus directed literal checks.
// Latency: outputs compared 1 ns after every rising edge.
// Backpressure: a DDR responder model drives random request-ready and beat gaps.
`timescale 1ns/1ps
module tb_pul_period_prefetch;
  localparam int DEPTH = 16;
  localparam int BURST = 8;
`ifdef PREFETCH_LAST_HOLD_EN
  localparam bit HOLD = 1'b1;
`else
  localparam bit HOLD = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic        read = 1'b0;
  logic [31:0] base_addr = '0;
  logic [31:0] total_words = '0;
  logic [31:0] pul_value;
  logic        empty, busy, done, underrun;

  pul_period_prefetch_if bus ();

  pul_period_prefetch #(.DEPTH(DEPTH), .BURST(BURST)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .base_addr(base_addr), .total_words(total_words), .rd(bus),
    .read(read), .pul_value(pul_value), .empty(empty), .busy(busy),
    .done(done), .underrun(underrun)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model state ----------------
  logic [31:0] q[$];
  logic [31:0] hold_m;
  bit          underrun_m, busy_m, done_m, drain_m;
  logic [31:0] job_base, job_total, issued, fetched;
  int          out_left;
  int          dut_done_cnt = 0;
  logic [31:0] req_addr_log[$];
  logic [7:0]  req_len_log[$];
  logic [31:0] beat_q[$];
  bit          pv_p;
  logic [31:0] pa_p;
  logic [7:0]  pl_p;
  logic [31:0] data_off = '0;
  int          ready_pct = 100;
  int          beat_pct = 100;

  function automatic logic [31:0] word_at(input logic [31:0] a);
    return (a >> 2) + data_off;
  endfunction

  task automatic model_reset();
    q.delete();
    beat_q.delete();
    hold_m = '0; underrun_m = 0; busy_m = 0; done_m = 0; drain_m = 0;
    issued = '0; fetched = '0; out_left = 0;
    pv_p = 0;
  endtask

  task automatic model_step();
    logic [31:0] rem;
    logic [31:0] el;
    done_m = 0;
    if (pv_p && bus.rd_req_ready) begin
      rem = job_total - issued;
      el  = (rem < BURST) ? rem : BURST;
      chk("req_while_idle", busy_m, 1);
      chk("req_one_outstanding", out_left, 0);
      chk("req_addr", pa_p, job_base + issued * 4);
      chk("req_len", pl_p, el);
      chk("req_room", (q.size() + pl_p <= DEPTH), 1);
      req_addr_log.push_back(pa_p);
      req_len_log.push_back(pl_p);
      out_left = pl_p;
      issued += pl_p;
      for (int i = 0; i < pl_p; i++) beat_q.push_back(pa_p + i * 4);
    end
    if (read && q.size() == 0) underrun_m = 1;
    else if (start && !busy_m && !abort) underrun_m = 0;
    if (read && !abort && q.size() > 0) hold_m = q.pop_front();
    if (bus.rd_data_valid) begin
      out_left--;
      if (!drain_m && !abort) begin
        q.push_back(bus.rd_data);
        fetched++;
      end
      if (out_left == 0) begin
        if (drain_m || abort) begin busy_m = 0; drain_m = 0; end
        else if (fetched == job_total) begin busy_m = 0; done_m = 1; end
      end
    end
    if (abort) begin
      q.delete();
      hold_m = '0;
      if (out_left > 0) drain_m = 1;
      else busy_m = 0;
    end
    if (start && !busy_m && !abort) begin
      job_base = base_addr; job_total = total_words;
      issued = '0; fetched = '0;
      if (total_words == '0) done_m = 1;
      else busy_m = 1;
    end
  endtask

  task automatic model_cmp();
    chk("empty", empty, q.size() == 0);
    chk("pul_value", pul_value, (q.size() > 0) ? q[0] : (HOLD ? hold_m : 32'd0));
    chk("busy", busy, busy_m);
    chk("done", done, done_m);
    chk("underrun", underrun, underrun_m);
    if (!busy_m || out_left > 0) chk("req_valid_quiet", bus.rd_req_valid, 0);
    if (pv_p && !bus.rd_req_ready && !abort) begin
      chk("req_valid_held", bus.rd_req_valid, 1);
      chk("req_addr_stable", bus.rd_req_addr, pa_p);
      chk("req_len_stable", bus.rd_req_len, pl_p);
    end
    if (done) dut_done_cnt++;
  endtask

  // Model update and comparison, once per cycle just after the rising edge.
  initial begin
    model_reset();
    forever begin
      @(posedge clk);
      #1;
      if (!rst_n) model_reset();
      else model_step();
      model_cmp();
      pv_p = bus.rd_req_valid;
      pa_p = bus.rd_req_addr;
      pl_p = bus.rd_req_len;
    end
  end

  // DDR reader model: random ready, queued beats delivered with random gaps.
  initial begin
    logic [31:0] a;
    bus.rd_req_ready = 1'b0;
    bus.rd_data_valid = 1'b0;
    bus.rd_data = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        beat_q.delete();
        bus.rd_req_ready = 1'b0;
        bus.rd_data_valid = 1'b0;
      end else begin
        bus.rd_req_ready = ($urandom_range(99) < ready_pct);
        if (beat_q.size() > 0 && $urandom_range(99) < beat_pct) begin
          a = beat_q.pop_front();
          bus.rd_data_valid = 1'b1;
          bus.rd_data = word_at(a);
        end else begin
          bus.rd_data_valid = 1'b0;
          bus.rd_data = $urandom;
        end
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog_timeout t=%0t", $time);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1);
  end

  task automatic drain_fifo(input string name, input int exp_pops);
    int pops;
    pops = 0;
    while (!empty && pops < 64) begin
      read = 1'b1;
      @(negedge clk);
      pops++;
    end
    read = 1'b0;
    chk(name, pops, exp_pops);
  endtask

  // Directed scenarios followed by randomized jobs.
  initial begin
    int n;
    int prev_done;
    logic [31:0] tmp;

    // Reset values
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_req_valid", bus.rd_req_valid, 0);
    chk("rst_req_addr", bus.rd_req_addr, 0);
    chk("rst_req_len", bus.rd_req_len, 0);
    chk("rst_pul_value", pul_value, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_underrun", underrun, 0);
    chk("rst_empty", empty, 1);
    rst_n = 1'b1;
    @(negedge clk);

    // 20 words 0x100..0x113 at 0x1000, immediate ready, no reads
    data_off = 32'h100 - 32'h400;
    req_addr_log.delete(); req_len_log.delete();
    base_addr = 32'h1000; total_words = 20; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("t1_req_not_yet", bus.rd_req_valid, 0);
    @(negedge clk);
    chk("t1_req_at_2", bus.rd_req_valid, 1);
    chk("t1_req0_addr", bus.rd_req_addr, 32'h1000);
    chk("t1_req0_len", bus.rd_req_len, 8);
    repeat (40) @(negedge clk);
    chk("t1_issued_16", issued, 16);
    chk("t1_req_count", req_addr_log.size(), 2);
    chk("t1_req1_addr", req_addr_log[1], 32'h1020);
    chk("t1_full_head", pul_value, 32'h100);
    chk("t1_wait_busy", busy, 1);
    chk("t1_wait_no_req", bus.rd_req_valid, 0);
    chk("t1_no_done_yet", dut_done_cnt, 0);
    read = 1'b1;
    repeat (4) @(negedge clk);
    read = 1'b0;
    chk("t1_head_after_4", pul_value, 32'h104);
    n = 0;
    while (dut_done_cnt == 0 && n < 100) begin @(negedge clk); n++; end
    chk("t1_done_seen", dut_done_cnt, 1);
    repeat (5) @(negedge clk);
    chk("t1_done_once", dut_done_cnt, 1);
    chk("t1_req2_addr", req_addr_log[2], 32'h1040);
    chk("t1_req2_len", req_len_log[2], 4);
    drain_fifo("t1_pops", 16);
    read = 1'b1;
    @(negedge clk);
    read = 1'b0;
    chk("t1_underrun", underrun, 1);
    chk("t1_empty_value", pul_value, HOLD ? 32'h113 : 32'h0);
    repeat (3) @(negedge clk);
    chk("t1_underrun_sticky", underrun, 1);

    // Read and push in the same cycle with count = 16 - len
    data_off = $urandom;
    prev_done = dut_done_cnt;
    base_addr = 32'h4000; total_words = 16; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("t2_underrun_cleared", underrun, 0);
    n = 0;
    while (issued != 16 && n < 100) begin @(negedge clk); n++; end
    chk("t2_second_burst", issued, 16);
    read = 1'b1;
    repeat (4) @(negedge clk);
    read = 1'b0;
    n = 0;
    while (dut_done_cnt == prev_done && n < 100) begin @(negedge clk); n++; end
    chk("t2_done", dut_done_cnt, prev_done + 1);
    drain_fifo("t2_pops", 12);

    // Abort after the 3rd beat of an 8-beat burst
    data_off = $urandom;
    prev_done = dut_done_cnt;
    base_addr = 32'h8000; total_words = 8; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (fetched < 3 && n < 100) begin @(negedge clk); n++; end
    chk("t3_three_beats", fetched, 3);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("t3_flushed", empty, 1);
    chk("t3_still_busy", busy, 1);
    n = 0;
    while (busy && n < 50) begin @(negedge clk); n++; end
    chk("t3_drain_cycles", n, 4);
    chk("t3_no_done", dut_done_cnt, prev_done);
    chk("t3_empty_after", empty, 1);
    chk("t3_beats_consumed", beat_q.size(), 0);

    // Asynchronous reset during DATA, then a zero-length job
    data_off = $urandom;
    base_addr = 32'h2000; total_words = 8; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (fetched < 2 && n < 100) begin @(negedge clk); n++; end
    chk("t4_in_data", fetched, 2);
    rst_n = 1'b0;
    #1;
    chk("t4_rst_req_valid", bus.rd_req_valid, 0);
    chk("t4_rst_req_addr", bus.rd_req_addr, 0);
    chk("t4_rst_req_len", bus.rd_req_len, 0);
    chk("t4_rst_pul_value", pul_value, 0);
    chk("t4_rst_busy", busy, 0);
    chk("t4_rst_empty", empty, 1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    req_addr_log.delete(); req_len_log.delete();
    base_addr = 32'h3000; total_words = 0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("t4_zero_done", done, 1);
    chk("t4_zero_not_busy", busy, 0);
    @(negedge clk);
    chk("t4_done_pulse", done, 0);
    repeat (4) @(negedge clk);
    chk("t4_no_request", req_addr_log.size(), 0);

    // Randomized jobs with random ready, beat gaps and reads
    ready_pct = 50; beat_pct = 60;
    for (int j = 0; j < 8; j++) begin
      data_off = $urandom;
      tmp = $urandom;
      prev_done = dut_done_cnt;
      base_addr = tmp & 32'hFFFF_FFFC;
      total_words = $urandom_range(40, 1);
      read = 1'b0;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      n = 0;
      while (dut_done_cnt == prev_done && n < 2000) begin
        read = ($urandom_range(99) < 35);
        @(negedge clk);
        n++;
      end
      read = 1'b0;
      chk("rnd_done", dut_done_cnt, prev_done + 1);
      n = 0;
      while (!empty && n < 64) begin read = 1'b1; @(negedge clk); n++; end
      read = 1'b0;
      chk("rnd_drained", empty, 1);
    end

    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pul_period_prefetch.md
# pul_period_prefetch

Prefetch buffer that sits directly upstream of the motor pulse controller. It fetches per-step pulse-period words from DDR through a simple burst read-request/data interface and stores them in a small first-word-fall-through FIFO. It presents the head word as `pul_value` and advances one word on each `read` strobe from the controller. Fetching runs ahead of consumption, so the controller never waits on DDR latency while a step is in progress.

## Interface
- `DEPTH`, 16: FIFO depth in 32-bit words; must be a power of 2 and ≥ `BURST`.
- `BURST`, 8: maximum words per read request, 1..255.
- `clk` input 1: clock.
- `rst_n` input 1: reset, asynchronous, active-low; clock `clk`.
- `start` input 1: one-cycle pulse that begins a fetch job; accepted only in IDLE.
- `abort` input 1: one-cycle pulse that cancels the job and flushes the FIFO.
- `base_addr` input 32: byte address of the first word, sampled on `start`; must be 4-byte aligned.
- `total_words` input 32: number of words in the job, sampled on `start`.
- `rd_req_valid` output 1: burst request valid.
- `rd_req_ready` input 1: burst request accepted by the DDR reader.
- `rd_req_addr` output 32: byte address of the burst.
- `rd_req_len` output 8: number of words in the burst.
- `rd_data_valid` input 1: data beat valid; there is no back-pressure and every valid beat must be accepted.
- `rd_data` input 32: data beat.
- `read` input 1: pop strobe from the controller.
- `pul_value` output 32: FIFO head word.
- `empty` output 1: FIFO holds no words.
- `busy` output 1: FSM not in IDLE.
- `done` output 1: one-cycle pulse when every word of the job has been written into the FIFO.
- `underrun` output 1: sticky flag, set when `read` arrives while `empty`; cleared on an accepted `start`.

## Operation
- State machine states:
  - IDLE: an accepted `start` latches the address and remaining count. If `total_words` = 0, pulse `done` and stay in IDLE; otherwise go to CHECK.
  - CHECK: compute `len` = min(`BURST`, remaining). If free slots (`DEPTH` − count) ≥ `len`, go to REQ; otherwise stay in CHECK until pops create room.
  - REQ: hold `rd_req_valid` = 1 with `rd_req_addr` and `rd_req_len` stable until `rd_req_ready`. On handshake, go to DATA with the beat counter set to `len`.
  - DATA: push each valid beat and decrement the beat counter. On the last beat, address += `len`×4 and remaining −= `len`. If remaining = 0, pulse `done` and go to IDLE; otherwise go to CHECK.
  - DRAIN: entered on `abort` from DATA; swallows the remaining beats of the outstanding burst without pushing them, then goes to IDLE.
- Only one burst is outstanding at any time. Space for the burst is reserved at CHECK, so a push can never overflow the FIFO.
- `abort` handling:
  - From CHECK or REQ: go to IDLE immediately.
  - From DATA: go to DRAIN.
  - In all cases the FIFO is flushed in the same cycle.
  - `abort` in IDLE only flushes the FIFO.
- Count arithmetic: count is `$clog2(DEPTH)+1` bits. A simultaneous push and pop leaves count unchanged. A pop while empty is ignored and sets `underrun`.
- Address arithmetic is 32-bit modulo; wrap-around past 0xFFFF_FFFC is not checked.
- `start` while `busy` is ignored.

## Timing
- Reset values:
  - `rd_req_valid`, `rd_req_addr`, `rd_req_len`, `pul_value`, `busy`, `done`, `underrun` = 0.
  - `empty` = 1.
  - State = IDLE, FIFO flushed.
- `start` to `rd_req_valid`: 2 cycles (IDLE→CHECK→REQ), provided there is room.
- Beat to output: a beat written into an empty FIFO appears on `pul_value` and drops `empty` on the next cycle.
- Pop: with `read` at edge N, the next head word is on `pul_value` after edge N.
- `done` rises in the cycle after the final beat is captured.

## Configuration
- `PREFETCH_LAST_HOLD_EN` defined: while `empty`, `pul_value` holds the last popped word. It is 0 only after reset or a flush.
- Not defined: `pul_value` = 0 whenever `empty`.

## Test plan
- `total_words`=20, `BURST`=8, immediate ready, no reads: bursts of 8 and 8 are issued; the FIFO fills to 16 and the FSM waits in CHECK; after 4 reads the last burst (`len`=4) is issued and `done` pulses once.
- Words 0x100..0x113 at `base_addr`=0x1000: addresses 0x1000, 0x1020, 0x1040; the popped sequence equals the data order exactly.
- `read` and a push in the same cycle with count=16−`len`: count is unchanged and no data is lost.
- `read` while `empty`: `underrun`=1 and stays set until the next `start`; `pul_value` = last word with `PREFETCH_LAST_HOLD_EN`, 0 without.
- `abort` after the 3rd beat of an 8-beat burst: the remaining 5 beats are discarded, `empty`=1, `busy` drops after the 8th beat, and `done` does not pulse.
- `rst_n` low during DATA: all outputs return to their reset values asynchronously; a following `start` with `total_words`=0 gives a `done` pulse one cycle later with no request issued.
